// File: rtl/gfx_pkg.sv
// Shared fixed-point types, constants and the perspective-divide FSM encoding.
package gfx_pkg;
    typedef logic signed [31:0] fixed_t;

    localparam int     FRAC_BITS = 16;
    localparam fixed_t FX_ONE    = 32'h0001_0000;

    typedef enum logic [1:0] {IDLE, DIV, SCALE, OUT} pd_state_t;

    // 16.16 multiply: full signed 64-bit product, rescaled and wrapped to 32 bits.
    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = a;
        eb = b;
        p  = (ea * eb) >>> FRAC_BITS;
        return fixed_t'(p);
    endfunction
endpackage

// File: rtl/fx_recip.sv
// Iterative reciprocal: floor(2^32 / d) in exactly 32 cycles after start,
// saturated to 0x7FFFFFFF. done is high during the cycle of the final iteration.
module fx_recip
    import gfx_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] d,
    output logic        busy,
    output logic        done,
    output fixed_t      recip
);
    logic [31:0] div;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [4:0]  cnt;
    logic [32:0] shifted;
    logic        ge;

    always_comb begin
        shifted = {rem, 1'b0};
        ge      = shifted >= {1'b0, div};
    end

    // Remainder starts at 1: the dividend's bit 32 is pre-shifted in, and its
    // quotient bit is only nonzero for d==1, which saturates anyway.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div  <= '0;
            rem  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            div  <= d;
            rem  <= 32'd1;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= ge ? (shifted[31:0] - div) : shifted[31:0];
            quo  <= {quo[30:0], ge};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) busy <= 1'b0;
        end
    end

    assign done  = busy && (cnt == 5'd31);
    assign recip = (div == 32'd1 || quo[31]) ? 32'h7FFF_FFFF : quo;
endmodule

// File: rtl/perspective_divide.sv
// Per-vertex perspective divide plus viewport map for one triangle at a time.
// Optional build macro PERSP_CLAMP_EN saturates screen x/y to the viewport.
module perspective_divide
    import gfx_pkg::*;
#(
    parameter int HALF_W = 320,
    parameter int HALF_H = 240,
    parameter int FRAC   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0][31:0] x_in,
    input  logic [3:0][31:0] y_in,
    input  logic [3:0][31:0] z_in,
    input  logic [3:0][31:0] w_in,
    input  logic             in_valid,
    input  logic             stall_in,
    output logic [2:0][31:0] sx_out,
    output logic [2:0][31:0] sy_out,
    output logic [2:0][31:0] sz_out,
    output logic [2:0]       cull_out,
    output logic             out_valid,
    output logic             stall_out
);
    function automatic fixed_t to_screen(input fixed_t ndc, input int half);
        logic signed [63:0] e;
        logic signed [63:0] v;
        e = ndc;
        v = e * 64'(half) + (64'(half) <<< FRAC);
`ifdef PERSP_CLAMP_EN
        if (v < 0) v = '0;
        else if (v > (64'(half) <<< (FRAC + 1)) - 1) v = (64'(half) <<< (FRAC + 1)) - 1;
`else
`endif
        return fixed_t'(v);
    endfunction

    pd_state_t        state;
    logic [1:0]       vidx;
    logic [1:0]       nxt;
    logic [2:0][31:0] x_r, y_r, z_r, w_r;
    fixed_t           cur_w, recip, recip_v, ndc_x, ndc_y, ndc_z;
    logic             cull_v;
    logic             div_start, div_done, div_busy_unused;
    logic [31:0]      div_d;
    logic             unused_lanes;

    assign unused_lanes = ^{x_in[3], y_in[3], z_in[3], w_in[3]};

    fx_recip u_recip (
        .clock (clock),
        .reset (reset),
        .start (div_start),
        .d     (div_d),
        .busy  (div_busy_unused),
        .done  (div_done),
        .recip (recip)
    );

    // The next vertex's divide starts on the same edge that retires the current one.
    always_comb begin
        nxt       = vidx + 2'd1;
        cur_w     = fixed_t'(w_r[vidx]);
        cull_v    = cur_w <= 0;
        recip_v   = cull_v ? '0 : recip;
        ndc_x     = fx_mul(fixed_t'(x_r[vidx]), recip_v);
        ndc_y     = fx_mul(fixed_t'(y_r[vidx]), recip_v);
        ndc_z     = fx_mul(fixed_t'(z_r[vidx]), recip_v);
        div_start = 1'b0;
        div_d     = w_in[0];
        if (state == IDLE && in_valid) begin
            div_start = 1'b1;
        end else if (state == SCALE && vidx != 2'd2) begin
            div_start = 1'b1;
            div_d     = w_r[nxt];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            vidx      <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            w_r       <= '0;
            sx_out    <= '0;
            sy_out    <= '0;
            sz_out    <= '0;
            cull_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_r   <= x_in[2:0];
                    y_r   <= y_in[2:0];
                    z_r   <= z_in[2:0];
                    w_r   <= w_in[2:0];
                    vidx  <= '0;
                    state <= DIV;
                end
                DIV: if (div_done) state <= SCALE;
                SCALE: begin
                    sx_out[vidx]   <= to_screen(ndc_x, HALF_W);
                    sy_out[vidx]   <= to_screen(ndc_y, HALF_H);
                    sz_out[vidx]   <= ndc_z;
                    cull_out[vidx] <= cull_v;
                    if (vidx == 2'd2) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        vidx  <= nxt;
                        state <= DIV;
                    end
                end
                OUT: if (!stall_in) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_out = (state != IDLE);
endmodule

// File: tb/tb_perspective_divide.sv
// Self-checking bench for perspective_divide against a plain-arithmetic model.
module tb_perspective_divide;
    localparam int HW = 320;
    localparam int HH = 240;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0][31:0] x_in, y_in, z_in, w_in;
    logic             in_valid, stall_in;
    logic [2:0][31:0] sx_out, sy_out, sz_out;
    logic [2:0]       cull_out;
    logic             out_valid, stall_out;

    logic [3:0][31:0] tx, ty, tz, tw;
    logic [2:0][31:0] esx, esy, esz;
    logic [2:0]       ecull;
    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    perspective_divide #(.HALF_W(HW), .HALF_H(HH), .FRAC(16)) dut (
        .clock(clock), .reset(reset),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .w_in(w_in),
        .in_valid(in_valid), .stall_in(stall_in),
        .sx_out(sx_out), .sy_out(sy_out), .sz_out(sz_out),
        .cull_out(cull_out), .out_valid(out_valid), .stall_out(stall_out)
    );

    function automatic logic [31:0] m_recip(input logic [31:0] w);
        logic [63:0] q;
        if ($signed(w) <= 0) return 32'd0;
        q = 64'h1_0000_0000 / {32'd0, w};
        if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        return q[31:0];
    endfunction

    function automatic logic [31:0] m_ndc(input logic [31:0] c, input logic [31:0] w);
        longint p;
        p = longint'($signed(c)) * longint'({32'd0, m_recip(w)});
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_screen(input logic [31:0] ndc, input int half);
        longint v;
        v = longint'($signed(ndc)) * half + longint'(half) * 65536;
`ifdef PERSP_CLAMP_EN
        if (v < 0) v = 0;
        if (v > longint'(half) * 131072 - 1) v = longint'(half) * 131072 - 1;
`endif
        return v[31:0];
    endfunction

    task automatic model_tri;
        for (int i = 0; i < 3; i++) begin
            esx[i]   = m_screen(m_ndc(tx[i], tw[i]), HW);
            esy[i]   = m_screen(m_ndc(ty[i], tw[i]), HH);
            esz[i]   = m_ndc(tz[i], tw[i]);
            ecull[i] = $signed(tw[i]) <= 0;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!out_valid && n < 300);
        if (!out_valid) n = -1;
    endtask

    task automatic drive_tri(output int lat);
        x_in = tx; y_in = ty; z_in = tz; w_in = tw;
        in_valid = 1'b1; stall_in = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_done(lat);
        model_tri();
    endtask

    task automatic leave_out;
        stall_in = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic rand_tri;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = $urandom_range(0, 9);
            tx[i] = $urandom; ty[i] = $urandom; tz[i] = $urandom;
            if (k == 0)      tw[i] = 32'd0;
            else if (k == 1) tw[i] = $urandom | 32'h8000_0000;
            else if (k == 2) tw[i] = $urandom_range(1, 3);
            else if (k == 3) tw[i] = 32'h7FFF_FFFF;
            else             tw[i] = $urandom_range(32'h100, 32'h0100_0000);
            if (k > 5) begin
                tx[i] = $urandom_range(0, 32'h0004_0000) - 32'h0002_0000;
                ty[i] = $urandom_range(0, 32'h0004_0000) - 32'h0002_0000;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; stall_in = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; w_in = '0;
        #2;
        checks++;
        if ({sx_out, sy_out, sz_out, cull_out, out_valid, stall_out} !== '0)
            $display("FAIL reset_state got sx=%h cull=%b ov=%b so=%b want all zero", sx_out, cull_out, out_valid, stall_out);
        else passed++;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_identity;
        int lat;
        tw = {4{32'h0001_0000}};
        tx = {32'h0, 32'h0003_0000, 32'hFFFE_0000, 32'h0000_8000};
        ty = {32'h0, 32'h0000_4000, 32'h0001_0000, 32'hFFFF_8000};
        tz = {32'h0, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_4000};
        drive_tri(lat);
        checks++; if (lat !== 99) $display("FAIL identity_latency got %0d want 99", lat); else passed++;
        checks++;
        if ({sx_out[0], sy_out[0], sz_out[0]} !== {32'h01E0_0000, 32'h0078_0000, 32'h0000_4000})
            $display("FAIL identity_v0 got %h %h %h want 01e00000 00780000 00004000", sx_out[0], sy_out[0], sz_out[0]);
        else passed++;
        checks++; if (sx_out !== esx) $display("FAIL identity_sx got %h want %h", sx_out, esx); else passed++;
        checks++; if (sy_out !== esy) $display("FAIL identity_sy got %h want %h", sy_out, esy); else passed++;
        checks++; if (sz_out !== esz) $display("FAIL identity_sz got %h want %h", sz_out, esz); else passed++;
        checks++; if (cull_out !== 3'b000) $display("FAIL identity_cull got %b want 000", cull_out); else passed++;
        leave_out();
    endtask

    task automatic test_true_divide;
        int lat;
        tx = {32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000};
        ty = {32'h0, 32'h0002_0000, 32'hFFFF_0000, 32'h0};
        tz = {32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0};
        tw = {32'h0, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000};
        drive_tri(lat);
        checks++; if (lat !== 99) $display("FAIL true_div_latency got %0d want 99", lat); else passed++;
        checks++;
        if ({sx_out[1], sx_out[2]} !== {32'h01E0_0000, 32'h0140_0000})
            $display("FAIL true_div_sx12 got %h %h want 01e00000 01400000", sx_out[1], sx_out[2]);
        else passed++;
        checks++; if (sy_out !== esy) $display("FAIL true_div_sy got %h want %h", sy_out, esy); else passed++;
        checks++; if (sz_out !== esz) $display("FAIL true_div_sz got %h want %h", sz_out, esz); else passed++;
        leave_out();
    endtask

    task automatic test_degenerate;
        int lat;
        tx = {32'h0, 32'h0005_0000, 32'h0003_0000, 32'h0};
        ty = {32'h0, 32'hFFF0_0000, 32'h0007_0000, 32'h0};
        tz = {32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0};
        tw = {32'h0, 32'hFFFF_0000, 32'h0, 32'h0001_0000};
        drive_tri(lat);
        checks++; if (lat !== 99) $display("FAIL degen_latency got %0d want 99", lat); else passed++;
        checks++; if (cull_out !== 3'b110) $display("FAIL degen_cull got %b want 110", cull_out); else passed++;
        checks++;
        if ({sx_out[1], sx_out[2], sy_out[1], sy_out[2]} !== {32'h0140_0000, 32'h0140_0000, 32'h00F0_0000, 32'h00F0_0000})
            $display("FAIL degen_screen got %h %h %h %h want 01400000 01400000 00f00000 00f00000", sx_out[1], sx_out[2], sy_out[1], sy_out[2]);
        else passed++;
        checks++; if (sz_out !== esz) $display("FAIL degen_sz got %h want %h", sz_out, esz); else passed++;
        leave_out();
    endtask

    task automatic test_random;
        int lat;
        for (int t = 0; t < 10; t++) begin
            rand_tri();
            drive_tri(lat);
            checks++; if (lat !== 99) $display("FAIL rand%0d_latency got %0d want 99", t, lat); else passed++;
            checks++; if (sx_out !== esx) $display("FAIL rand%0d_sx got %h want %h", t, sx_out, esx); else passed++;
            checks++; if (sy_out !== esy) $display("FAIL rand%0d_sy got %h want %h", t, sy_out, esy); else passed++;
            checks++; if (sz_out !== esz) $display("FAIL rand%0d_sz got %h want %h", t, sz_out, esz); else passed++;
            checks++; if (cull_out !== ecull) $display("FAIL rand%0d_cull got %b want %b", t, cull_out, ecull); else passed++;
            leave_out();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        rand_tri();
        drive_tri(lat);
        stall_in = 1'b1; in_valid = 1'b1;
        rand_tri();
        x_in = tx; y_in = ty; z_in = tz; w_in = tw;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || stall_out !== 1'b1)
                $display("FAIL bp_hold%0d_flags got ov=%b so=%b want 1 1", c, out_valid, stall_out);
            else passed++;
            checks++;
            if ({sx_out, sy_out, sz_out, cull_out} !== {esx, esy, esz, ecull})
                $display("FAIL bp_hold%0d_data got %h %h want %h %h", c, sx_out, sz_out, esx, esz);
            else passed++;
        end
        stall_in = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0 || stall_out !== 1'b0)
            $display("FAIL bp_release got ov=%b so=%b want 0 0", out_valid, stall_out);
        else passed++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++; if (stall_out !== 1'b1) $display("FAIL bp_accept got so=%b want 1", stall_out); else passed++;
        wait_done(lat);
        model_tri();
        checks++; if (lat !== 99) $display("FAIL bp_latency got %0d want 99", lat); else passed++;
        checks++;
        if ({sx_out, sy_out, sz_out, cull_out} !== {esx, esy, esz, ecull})
            $display("FAIL bp_next_data got %h %h want %h %h", sx_out, sy_out, esx, esy);
        else passed++;
        leave_out();
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        rand_tri();
        x_in = tx; y_in = ty; z_in = tz; w_in = tw;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({sx_out, sy_out, sz_out, cull_out, out_valid, stall_out} !== '0)
            $display("FAIL rst_mid_clear got sx=%h cull=%b ov=%b so=%b want all zero", sx_out, cull_out, out_valid, stall_out);
        else passed++;
        @(negedge clock); reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rst_mid_no_emit got %0d valid cycles want 0", seen); else passed++;
        rand_tri();
        drive_tri(lat);
        checks++; if (lat !== 99) $display("FAIL rst_mid_latency got %0d want 99", lat); else passed++;
        checks++;
        if ({sx_out, sy_out, sz_out, cull_out} !== {esx, esy, esz, ecull})
            $display("FAIL rst_mid_data got %h %h want %h %h", sx_out, sz_out, esx, esz);
        else passed++;
        leave_out();
    endtask

    task automatic test_clamp;
        int lat;
        logic [31:0] want;
`ifdef PERSP_CLAMP_EN
        want = 32'h027F_FFFF;
`else
        want = 32'h0640_0000;
`endif
        tx = {32'h0, 32'hFFFA_0000, 32'h0, 32'h0004_0000};
        ty = {32'h0, 32'h0, 32'h0003_0000, 32'h0};
        tz = '0;
        tw = {4{32'h0001_0000}};
        drive_tri(lat);
        checks++; if (sx_out[0] !== want) $display("FAIL clamp_sx0 got %h want %h", sx_out[0], want); else passed++;
        checks++; if (sx_out !== esx) $display("FAIL clamp_sx got %h want %h", sx_out, esx); else passed++;
        checks++; if (sy_out !== esy) $display("FAIL clamp_sy got %h want %h", sy_out, esy); else passed++;
        leave_out();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_true_divide();
        test_degenerate();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_clamp();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
